// File: rtl/bcd_result_display.sv
// bcd_result_display
//   Consumer of the 4-digit BCD divider. Latches quotient/remainder on the
//   rising edge of end_division and scans them onto a 4-digit multiplexed
//   7-segment display, one digit every SCAN_DIV clocks. Nibbles above 9 are
//   drawn as 'E' and raise bcd_err.
//
//   Optional build macro: LEADING_ZERO_BLANK_EN
//     When defined, leading-zero digits (never digit 0) are blanked in place;
//     the scan keeps its timing.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   end_division  divider finish (pulse or level; rising edge captures)
//   quotient      BCD quotient, digit0 = [3:0]
//   remainder     BCD remainder, same packing
//   sel           0 = show quotient, 1 = show remainder
//   seg           segments {g,f,e,d,c,b,a}, active-high, registered
//   an            one-hot digit enable, active-high, registered
//   valid         a result has been captured
//   bcd_err       displayed value has a nibble > 9, registered
module bcd_result_display #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        end_division,
    input  logic [15:0] quotient,
    input  logic [15:0] remainder,
    input  logic        sel,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        valid,
    output logic        bcd_err
);

    localparam int            PW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    typedef enum logic {EMPTY, SHOW} state_t;

    state_t        state, state_nxt;
    logic          end_prev;
    logic          cap;
    logic [15:0]   q_r, r_r, q_nxt, r_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [1:0]    digit, digit_nxt;

    logic [15:0]   disp_val;
    logic [3:0]    nib;
    logic [3:0]    nib_bad;
    logic [6:0]    seg_nxt;
    logic [3:0]    an_nxt;
    logic          err_nxt;

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    seg_decode = 7'h3F;
            4'd1:    seg_decode = 7'h06;
            4'd2:    seg_decode = 7'h5B;
            4'd3:    seg_decode = 7'h4F;
            4'd4:    seg_decode = 7'h66;
            4'd5:    seg_decode = 7'h6D;
            4'd6:    seg_decode = 7'h7D;
            4'd7:    seg_decode = 7'h07;
            4'd8:    seg_decode = 7'h7F;
            4'd9:    seg_decode = 7'h6F;
            default: seg_decode = 7'h79;   // 'E' for A..F
        endcase
    endfunction

    // A held level must only capture once, so look for the rising edge.
    assign cap   = end_division & ~end_prev;
    assign valid = (state == SHOW);

    // ---------------- control / scan state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            end_prev <= 1'b0;
            q_r      <= '0;
            r_r      <= '0;
            presc    <= '0;
            digit    <= '0;
        end else begin
            state    <= state_nxt;
            end_prev <= end_division;
            q_r      <= q_nxt;
            r_r      <= r_nxt;
            presc    <= presc_nxt;
            digit    <= digit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        r_nxt     = r_r;
        presc_nxt = presc;
        digit_nxt = digit;
        case (state)
            EMPTY: begin
                if (cap) begin
                    q_nxt     = quotient;
                    r_nxt     = remainder;
                    presc_nxt = '0;
                    digit_nxt = '0;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                // A fresh capture restarts the scan even on a wrap cycle.
                if (cap) begin
                    q_nxt     = quotient;
                    r_nxt     = remainder;
                    presc_nxt = '0;
                    digit_nxt = '0;
                end else if (presc == PRESC_MAX) begin
                    presc_nxt = '0;
                    digit_nxt = digit + 2'd1;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // ---------------- display path ----------------
    assign disp_val = sel ? r_r : q_r;
    assign nib      = disp_val[{digit, 2'b00} +: 4];

    for (genvar i = 0; i < 4; i++) begin : g_nib
        assign nib_bad[i] = (disp_val[4*i +: 4] > 4'd9);
    end

`ifdef LEADING_ZERO_BLANK_EN
    // blank[i]: every nibble from position i upward is zero.
    logic [3:0] blank;
    assign blank[0] = 1'b0;
    for (genvar i = 1; i < 4; i++) begin : g_blank
        assign blank[i] = (disp_val[15:4*i] == '0);
    end
`endif

    always_comb begin
        seg_nxt = '0;
        an_nxt  = '0;
        err_nxt = 1'b0;
        if (state == SHOW) begin
            seg_nxt = seg_decode(nib);
            an_nxt  = 4'b0001 << digit;
            err_nxt = |nib_bad;
`ifdef LEADING_ZERO_BLANK_EN
            if (blank[digit]) begin
                seg_nxt = '0;
                an_nxt  = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg     <= '0;
            an      <= '0;
            bcd_err <= 1'b0;
        end else begin
            seg     <= seg_nxt;
            an      <= an_nxt;
            bcd_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_result_display.sv
module tb_bcd_result_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        end_division = 1'b0;
    logic [15:0] quotient = '0;
    logic [15:0] remainder = '0;
    logic        sel = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        valid;
    logic        bcd_err;

    bcd_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst(rst), .end_division(end_division),
        .quotient(quotient), .remainder(remainder), .sel(sel),
        .seg(seg), .an(an), .valid(valid), .bcd_err(bcd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       valid;
        logic       err;
    } obs_t;

    obs_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

    // Reference model: what the display should show, given how many clocks
    // have elapsed since the last capture.
    bit          m_prev  = 0;
    bit          m_shown = 0;
    logic [15:0] m_q = '0, m_r = '0;
    int          m_since = 0;

    function automatic obs_t display(bit shown, logic s, logic [15:0] q, logic [15:0] r, int since);
        obs_t        e;
        logic [15:0] v;
        logic [3:0]  n;
        int          d;
        e = '0;
        if (!shown) return e;
        v = s ? r : q;
        d = (since / SCAN_DIV) % 4;
        n = v[4*d +: 4];
        e.seg = seg_tbl[n];
        e.an  = 4'(1 << d);
        for (int k = 0; k < 4; k++)
            if (v[4*k +: 4] > 4'd9) e.err = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        if (d > 0 && (v >> (4*d)) == 16'd0) begin
            e.seg = '0;
            e.an  = '0;
        end
`endif
        return e;
    endfunction

    task automatic model_step();
        obs_t e;
        bit   cap;
        if (rst) begin
            e = '0;
            m_prev = 0; m_shown = 0; m_q = '0; m_r = '0; m_since = 0;
        end else begin
            e   = display(m_shown, sel, m_q, m_r, m_since);
            cap = end_division && !m_prev;
            m_prev = end_division;
            if (cap) begin
                m_shown = 1; m_q = quotient; m_r = remainder; m_since = 0;
            end else if (m_shown) begin
                m_since++;
            end
            e.valid = m_shown;
        end
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: outputs are registered, so every cycle presents one result.
    initial begin
        obs_t e, a;
        forever begin
            @(negedge clk);
            a = {seg, an, valid, bcd_err};
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty t=%0t got seg=%h an=%b valid=%b err=%b, no expectation queued",
                         $time, a.seg, a.an, a.valid, a.err);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL disp t=%0t got seg=%h an=%b valid=%b err=%b exp seg=%h an=%b valid=%b err=%b",
                             $time, a.seg, a.an, a.valid, a.err, e.seg, e.an, e.valid, e.err);
                end
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse();
        end_division = 1'b1;
        step(1);
        end_division = 1'b0;
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] v;
        int          lead;
        v = '0;
        lead = $urandom_range(0, 4);
        for (int k = 0; k < 4 - lead; k++)
            v[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        // 1: reset and idle
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(50);

        // 2: capture and scan
        quotient = 16'h0123; remainder = 16'h0045; sel = 1'b0;
        pulse();
        step(20);

        // 3: select switch while digit 0 shown (restart scan first)
        pulse();
        step(1);
        sel = 1'b1;
        step(20);
        sel = 1'b0;

        // 4: held level, then pulses at every phase of the scan
        quotient = 16'h9999;
        end_division = 1'b1;
        step(10);
        end_division = 1'b0;
        quotient = 16'h1234;
        step(20);
        for (int g = 1; g <= 9; g++) begin
            quotient = rand_val();
            pulse();
            step(g);
        end

        // 5: invalid BCD
        quotient = 16'h1A03; remainder = 16'h0000; sel = 1'b0;
        pulse();
        quotient = 16'h5555;
        step(20);
        sel = 1'b1;
        step(10);

        // 6: reset mid-scan, then recapture
        sel = 1'b0;
        quotient = 16'h4321;
        pulse();
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        pulse();
        step(20);

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            quotient  = rand_val();
            remainder = rand_val();
            if ($urandom_range(0, 29) == 0) end_division = ~end_division;
            if ($urandom_range(0, 14) == 0) sel = ~sel;
            rst = ($urandom_range(0, 599) == 0);
            step(1);
        end
        rst = 1'b0;
        end_division = 1'b0;
        step(3);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
